lock_entry_sequencer: RTL and testbench
=======================================

// Module: lock_entry_sequencer
// PURPOSE
// - Sequencer between the keypad decoder and the digital-lock FSM. It collects 4 keypad digits into the SSD nibbles.
// - It compares the entry against the stored 16-bit password and drives the unlock window.
// - It counts failed attempts and enforces a timed lockout. During lockout, entries are ignored.
// - Timing uses the shared 25 Hz pulse as a clock enable. Outputs feed the lock LED/RGB mux and ssd_0..ssd_3.
// PARAMETERS
// - MAX_FAILS      3    consecutive mismatches that cause a lockout (>=1)
// - FAIL_TICKS     25   FAIL indication length, in 25 Hz ticks (1 s)
// - UNLOCK_TICKS   125  UNLOCKED hold time, in ticks (5 s)
// - ENTRY_TIMEOUT  125  idle ticks between digits before the entry is abandoned (5 s)
// - LOCKOUT_TICKS  250  base lockout length, in ticks (10 s)
// PORTS
// - clk             in   1   system clock
// - rst             in   1   synchronous, active-high reset
// - tick            in   1   1-cycle 25 Hz enable pulse
// - key_valid       in   1   1-cycle pulse: key_value is a new keypress
// - key_value       in   4   keypad code: 0-9 = digit, 4'hC = clear, others ignored
// - password        in   16  stored code {d3,d2,d1,d0}; sampled in CHECK
// - ssd_0..ssd_3    out  4   entered digits; ssd_0 is the newest
// - digit_count     out  3   number of digits entered so far (0-4)
// - unlocked        out  1   high in UNLOCKED
// - fail_flag       out  1   high in FAIL
// - lockout         out  1   high in LOCKOUT
// - fail_count      out  2   consecutive mismatches (width = $clog2(MAX_FAILS+1))
// - state_code      out  3   IDLE=0 ENTRY=1 CHECK=2 UNLOCKED=3 FAIL=4 LOCKOUT=5
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0. Tick counter and fail_count are 0. Reset mid-state aborts the state on the next edge.
// - Key acceptance
//   - Keys are accepted only in IDLE and ENTRY. In all other states they are dropped with no side effects.
//   - Digit key: {ssd_3..ssd_0} <= {ssd_2,ssd_1,ssd_0,key}; digit_count++; the tick counter is zeroed.
//   - IDLE -> ENTRY on the first digit.
//   - On the 4th digit -> CHECK, registered on the same edge (digit_count=4).
// - Clear key (4'hC)
//   - In ENTRY: ssd and digit_count are zeroed -> IDLE. fail_count is unchanged.
//   - In IDLE: no-op.
// - Entry timeout: in ENTRY, on the tick with counter == ENTRY_TIMEOUT-1, digits are cleared -> IDLE. This does not count as a failure.
// - Simultaneous key_valid and tick: the key wins; the counter restarts at 0.
// - CHECK lasts exactly 1 cycle. It compares {ssd_3,ssd_2,ssd_1,ssd_0} == password.
//   - Match -> UNLOCKED; fail_count <= 0.
//   - Mismatch, fail_count+1 < MAX_FAILS -> FAIL; fail_count++.
//   - Mismatch, fail_count+1 == MAX_FAILS -> LOCKOUT; fail_count <= 0.
//   - Leaving CHECK clears ssd_* and digit_count.
// - Timed states (UNLOCKED / FAIL / LOCKOUT)
//   - Each holds for its tick budget, counted from a zeroed counter on entry.
//   - Exit -> IDLE on the tick where counter == budget-1.
//   - Latency: from the 4th key, unlocked rises 2 edges later.
// - State flags are registered and mutually exclusive. fail_count saturates and never wraps.
// - The tick counter is wide enough for the largest budget, including the backoff case.
// CONFIGURATION
// - Macro: LOCK_LOCKOUT_BACKOFF_EN
//   - Defined
//     - A 2-bit lockout_level register, reset 0, is added.
//     - The lockout budget is LOCKOUT_TICKS << lockout_level.
//     - lockout_level increments at each LOCKOUT exit and saturates at 3 (max 8x).
//     - lockout_level is cleared on entry to UNLOCKED.
//   - Undefined
//     - Every lockout lasts LOCKOUT_TICKS. lockout_level is not synthesized.
// TESTING
// - Reset, then keys 1,2,3,4 with password 16'h1234 -> CHECK, then unlocked=1 for 125 ticks, then IDLE with ssd_*=0.
// - Keys 1,2,3,5 three times, password 16'h1234 -> FAIL, fail_count=1; FAIL, fail_count=2; then LOCKOUT 250 ticks with fail_count=0.
// - During LOCKOUT, pulse keys 1,2,3,4 -> digit_count stays 0 and the state stays 5.
// - Keys 7,8, then 125 ticks with no key -> IDLE, ssd cleared, fail_count unchanged.
// - Keys 9,9, then 4'hC -> IDLE, digit_count=0.
// - Key_valid on the same cycle as tick at counter 124 -> the digit is accepted and there is no timeout.
// - With LOCK_LOCKOUT_BACKOFF_EN: 2nd lockout = 500 ticks, 4th and later = 2000 ticks; correct code resets the next lockout to 250.

Source files
------------

// File: rtl/lock_entry_sequencer.sv
// Keypad entry sequencer for the digital lock: gathers 4 digits, checks them against the stored
// code, and times the unlock / fail / lockout windows off the 25 Hz tick. Optional: LOCK_LOCKOUT_BACKOFF_EN.
module lock_entry_sequencer #(
    parameter int MAX_FAILS     = 3,
    parameter int FAIL_TICKS    = 25,
    parameter int UNLOCK_TICKS  = 125,
    parameter int ENTRY_TIMEOUT = 125,
    parameter int LOCKOUT_TICKS = 250,
    localparam int FCW          = $clog2(MAX_FAILS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           key_valid,
    input  logic [3:0]     key_value,
    input  logic [15:0]    password,
    output logic [3:0]     ssd_0,
    output logic [3:0]     ssd_1,
    output logic [3:0]     ssd_2,
    output logic [3:0]     ssd_3,
    output logic [2:0]     digit_count,
    output logic           unlocked,
    output logic           fail_flag,
    output logic           lockout,
    output logic [FCW-1:0] fail_count,
    output logic [2:0]     state_code
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTRY    = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_UNLOCKED = 3'd3;
    localparam logic [2:0] S_FAIL     = 3'd4;
    localparam logic [2:0] S_LOCKOUT  = 3'd5;

`ifdef LOCK_LOCKOUT_BACKOFF_EN
    localparam int LOCKOUT_MAX = LOCKOUT_TICKS * 8;
`else
    localparam int LOCKOUT_MAX = LOCKOUT_TICKS;
`endif
    localparam int BUDGET_A   = (FAIL_TICKS > UNLOCK_TICKS) ? FAIL_TICKS : UNLOCK_TICKS;
    localparam int BUDGET_B   = (ENTRY_TIMEOUT > LOCKOUT_MAX) ? ENTRY_TIMEOUT : LOCKOUT_MAX;
    localparam int MAX_BUDGET = (BUDGET_A > BUDGET_B) ? BUDGET_A : BUDGET_B;
    localparam int CW         = $clog2(MAX_BUDGET + 1);

    logic [2:0]     state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [15:0]    digits_reg, digits_next;
    logic [2:0]     dcount_reg, dcount_next;
    logic [FCW-1:0] fails_reg, fails_next;
    logic           unlocked_reg, fail_flag_reg, lockout_reg;
    logic [CW-1:0]  lockout_last, budget_last;
    logic           is_digit, is_clear, at_last;

`ifdef LOCK_LOCKOUT_BACKOFF_EN
    logic [1:0]     level_reg, level_next;
    assign lockout_last = CW'((LOCKOUT_TICKS << level_reg) - 1);
`else
    assign lockout_last = CW'(LOCKOUT_TICKS - 1);
`endif

    assign is_digit = (key_value <= 4'd9);
    assign is_clear = (key_value == 4'hC);

    // Last counter value of the current state's budget; the exit happens on the tick that sees it.
    always_comb begin
        budget_last = '0;
        case (state_reg)
            S_ENTRY:    budget_last = CW'(ENTRY_TIMEOUT - 1);
            S_UNLOCKED: budget_last = CW'(UNLOCK_TICKS - 1);
            S_FAIL:     budget_last = CW'(FAIL_TICKS - 1);
            S_LOCKOUT:  budget_last = lockout_last;
            default:    budget_last = '0;
        endcase
    end

    assign at_last = (cnt_reg == budget_last);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        digits_next = digits_reg;
        dcount_next = dcount_reg;
        fails_next  = fails_reg;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
        level_next  = level_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (key_valid && is_digit) begin
                    digits_next = {digits_reg[11:0], key_value};
                    dcount_next = 3'd1;
                    state_next  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                // A key on the same cycle as a tick takes priority and restarts the idle count.
                if (key_valid && is_digit) begin
                    digits_next = {digits_reg[11:0], key_value};
                    dcount_next = dcount_reg + 3'd1;
                    cnt_next    = '0;
                    if (dcount_reg == 3'd3) begin
                        state_next = S_CHECK;
                    end
                end else if (key_valid && is_clear) begin
                    digits_next = '0;
                    dcount_next = '0;
                    cnt_next    = '0;
                    state_next  = S_IDLE;
                end else if (tick) begin
                    if (at_last) begin
                        digits_next = '0;
                        dcount_next = '0;
                        cnt_next    = '0;
                        state_next  = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            S_CHECK: begin
                digits_next = '0;
                dcount_next = '0;
                cnt_next    = '0;
                if (digits_reg == password) begin
                    state_next = S_UNLOCKED;
                    fails_next = '0;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
                    level_next = 2'd0;
`endif
                end else if (int'(fails_reg) + 1 < MAX_FAILS) begin
                    state_next = S_FAIL;
                    fails_next = fails_reg + FCW'(1);
                end else begin
                    state_next = S_LOCKOUT;
                    fails_next = '0;
                end
            end
            S_UNLOCKED, S_FAIL, S_LOCKOUT: begin
                if (tick) begin
                    if (at_last) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
                        if (state_reg == S_LOCKOUT && level_reg != 2'd3) begin
                            level_next = level_reg + 2'd1;
                        end
`endif
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next  = S_IDLE;
                cnt_next    = '0;
                digits_next = '0;
                dcount_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            digits_reg    <= '0;
            dcount_reg    <= '0;
            fails_reg     <= '0;
            unlocked_reg  <= 1'b0;
            fail_flag_reg <= 1'b0;
            lockout_reg   <= 1'b0;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
            level_reg     <= 2'd0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            digits_reg    <= digits_next;
            dcount_reg    <= dcount_next;
            fails_reg     <= fails_next;
            unlocked_reg  <= (state_next == S_UNLOCKED);
            fail_flag_reg <= (state_next == S_FAIL);
            lockout_reg   <= (state_next == S_LOCKOUT);
`ifdef LOCK_LOCKOUT_BACKOFF_EN
            level_reg     <= level_next;
`endif
        end
    end

    assign ssd_0       = digits_reg[3:0];
    assign ssd_1       = digits_reg[7:4];
    assign ssd_2       = digits_reg[11:8];
    assign ssd_3       = digits_reg[15:12];
    assign digit_count = dcount_reg;
    assign unlocked    = unlocked_reg;
    assign fail_flag   = fail_flag_reg;
    assign lockout     = lockout_reg;
    assign fail_count  = fails_reg;
    assign state_code  = state_reg;

endmodule

// File: tb/tb_lock_entry_sequencer.sv
// Bench for lock_entry_sequencer: directed scenarios plus random keys/ticks/resets checked
// against a digit-queue / countdown reference model.
module tb_lock_entry_sequencer;

    localparam int MAX_FAILS     = 3;
    localparam int FAIL_TICKS    = 25;
    localparam int UNLOCK_TICKS  = 125;
    localparam int ENTRY_TIMEOUT = 125;
    localparam int LOCKOUT_TICKS = 250;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = 4'd0;
    logic [15:0] password = 16'h1234;
    logic [3:0]  ssd_0, ssd_1, ssd_2, ssd_3;
    logic [2:0]  digit_count;
    logic        unlocked, fail_flag, lockout;
    logic [1:0]  fail_count;
    logic [2:0]  state_code;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lock_entry_sequencer #(
        .MAX_FAILS     (MAX_FAILS),
        .FAIL_TICKS    (FAIL_TICKS),
        .UNLOCK_TICKS  (UNLOCK_TICKS),
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT),
        .LOCKOUT_TICKS (LOCKOUT_TICKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .password    (password),
        .ssd_0       (ssd_0),
        .ssd_1       (ssd_1),
        .ssd_2       (ssd_2),
        .ssd_3       (ssd_3),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .fail_flag   (fail_flag),
        .lockout     (lockout),
        .fail_count  (fail_count),
        .state_code  (state_code)
    );

    // Reference model: entered digits as a queue (oldest first), ticks left in the current window.
    int m_state;
    int m_fails;
    int m_remain;
    int m_digits[$];
`ifdef LOCK_LOCKOUT_BACKOFF_EN
    int m_level;
`endif

    function automatic void model_reset();
        m_state  = 0;
        m_fails  = 0;
        m_remain = 0;
        m_digits.delete();
`ifdef LOCK_LOCKOUT_BACKOFF_EN
        m_level  = 0;
`endif
    endfunction

    function automatic void model_step(input logic kv, input logic [3:0] kval, input logic tk, input logic r);
        bit dig;
        bit clr;
        int entered;
        dig = kv && (kval <= 4'd9);
        clr = kv && (kval == 4'hC);
        if (r) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (dig) begin
                m_digits.push_back(int'(kval));
                m_remain = ENTRY_TIMEOUT;
                m_state  = 1;
            end
            1: if (dig) begin
                m_digits.push_back(int'(kval));
                m_remain = ENTRY_TIMEOUT;
                if (m_digits.size() == 4) m_state = 2;
            end else if (clr) begin
                m_digits.delete();
                m_state = 0;
            end else if (tk) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_digits.delete();
                    m_state = 0;
                end
            end
            2: begin
                entered = 0;
                foreach (m_digits[i]) entered = entered * 16 + m_digits[i];
                m_digits.delete();
                if (entered == int'(password)) begin
                    m_state  = 3;
                    m_fails  = 0;
                    m_remain = UNLOCK_TICKS;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
                    m_level  = 0;
`endif
                end else if (m_fails + 1 < MAX_FAILS) begin
                    m_state  = 4;
                    m_fails  = m_fails + 1;
                    m_remain = FAIL_TICKS;
                end else begin
                    m_state  = 5;
                    m_fails  = 0;
`ifdef LOCK_LOCKOUT_BACKOFF_EN
                    m_remain = LOCKOUT_TICKS * (1 << m_level);
`else
                    m_remain = LOCKOUT_TICKS;
`endif
                end
                $display("txn: entry=%04h password=%04h result_state=%0d fails=%0d", entered, password, m_state, m_fails);
            end
            default: if (tk) begin
                m_remain--;
                if (m_remain == 0) begin
`ifdef LOCK_LOCKOUT_BACKOFF_EN
                    if (m_state == 5 && m_level < 3) m_level++;
`endif
                    m_state = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [15:0] exp_digits();
        logic [15:0] v;
        int n;
        v = 16'h0;
        n = m_digits.size();
        for (int k = 0; k < 4; k++) begin
            if (k < n) v[4*k +: 4] = 4'(m_digits[n-1-k]);
        end
        return v;
    endfunction

    task automatic step(input logic kv, input logic [3:0] kval, input logic tk, input logic r);
        key_valid = kv;
        key_value = kval;
        tick      = tk;
        rst       = r;
        @(posedge clk);
        model_step(kv, kval, tk, r);
        #1;
        key_valid = 1'b0;
        tick      = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 4'd0, 1'b1, 1'b0);
            idle();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 1'b1, 1'b1);
        total++;
        if (state_code !== 3'd0) begin
            bad++; $display("FAIL reset_state: got %0d want 0", state_code);
        end
        total++;
        if ({ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0) begin
            bad++; $display("FAIL reset_ssd: got %04h want 0000", {ssd_3, ssd_2, ssd_1, ssd_0});
        end
        total++;
        if ({digit_count, unlocked, fail_flag, lockout, fail_count} !== 8'h0) begin
            bad++; $display("FAIL reset_outputs: got %02h want 00", {digit_count, unlocked, fail_flag, lockout, fail_count});
        end
    endtask

    task automatic test_unlock();
        password = 16'h1234;
        key(4'd1); key(4'd2); key(4'd3);
        total++;
        if (state_code !== 3'd1 || digit_count !== 3'd3 || {ssd_2, ssd_1, ssd_0} !== 12'h123) begin
            bad++; $display("FAIL entry_shift: state=%0d count=%0d ssd=%03h want 1 3 123", state_code, digit_count, {ssd_2, ssd_1, ssd_0});
        end
        key(4'd4);
        total++;
        if (state_code !== 3'd2 || digit_count !== 3'd4 || unlocked !== 1'b0) begin
            bad++; $display("FAIL check_state: state=%0d count=%0d unlocked=%0b want 2 4 0", state_code, digit_count, unlocked);
        end
        idle();
        total++;
        if (state_code !== 3'd3 || unlocked !== 1'b1) begin
            bad++; $display("FAIL unlock_rise: state=%0d unlocked=%0b want 3 1", state_code, unlocked);
        end
        total++;
        if ({ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0 || digit_count !== 3'd0) begin
            bad++; $display("FAIL unlock_clear: ssd=%04h count=%0d want 0000 0", {ssd_3, ssd_2, ssd_1, ssd_0}, digit_count);
        end
        ticks(UNLOCK_TICKS - 1);
        total++;
        if (unlocked !== 1'b1) begin
            bad++; $display("FAIL unlock_hold: unlocked=%0b want 1", unlocked);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0 || unlocked !== 1'b0) begin
            bad++; $display("FAIL unlock_exit: state=%0d unlocked=%0b want 0 0", state_code, unlocked);
        end
    endtask

    task automatic test_fail_lockout();
        for (int a = 1; a <= MAX_FAILS; a++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd5);
            idle();
            if (a < MAX_FAILS) begin
                total++;
                if (state_code !== 3'd4 || fail_flag !== 1'b1 || int'(fail_count) !== a) begin
                    bad++; $display("FAIL fail_enter: state=%0d flag=%0b count=%0d want 4 1 %0d", state_code, fail_flag, fail_count, a);
                end
                ticks(FAIL_TICKS - 1);
                total++;
                if (state_code !== 3'd4) begin
                    bad++; $display("FAIL fail_hold: state=%0d want 4", state_code);
                end
                ticks(1);
                total++;
                if (state_code !== 3'd0 || fail_flag !== 1'b0) begin
                    bad++; $display("FAIL fail_exit: state=%0d flag=%0b want 0 0", state_code, fail_flag);
                end
            end else begin
                total++;
                if (state_code !== 3'd5 || lockout !== 1'b1 || fail_count !== 2'd0) begin
                    bad++; $display("FAIL lockout_enter: state=%0d lockout=%0b count=%0d want 5 1 0", state_code, lockout, fail_count);
                end
            end
        end
    endtask

    task automatic test_lockout_ignores_keys();
        ticks(10);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        total++;
        if (digit_count !== 3'd0 || state_code !== 3'd5 || {ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0) begin
            bad++; $display("FAIL lockout_keys: count=%0d state=%0d ssd=%04h want 0 5 0000", digit_count, state_code, {ssd_3, ssd_2, ssd_1, ssd_0});
        end
        ticks(LOCKOUT_TICKS - 11);
        total++;
        if (state_code !== 3'd5 || lockout !== 1'b1) begin
            bad++; $display("FAIL lockout_hold: state=%0d lockout=%0b want 5 1", state_code, lockout);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0 || lockout !== 1'b0) begin
            bad++; $display("FAIL lockout_exit: state=%0d lockout=%0b want 0 0", state_code, lockout);
        end
    endtask

    task automatic test_entry_timeout();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        idle();
        ticks(FAIL_TICKS);
        key(4'd7); key(4'd8);
        ticks(ENTRY_TIMEOUT - 1);
        total++;
        if (state_code !== 3'd1 || ssd_1 !== 4'd7 || ssd_0 !== 4'd8) begin
            bad++; $display("FAIL timeout_hold: state=%0d ssd1=%0d ssd0=%0d want 1 7 8", state_code, ssd_1, ssd_0);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0 || digit_count !== 3'd0 || {ssd_3, ssd_2, ssd_1, ssd_0} !== 16'h0) begin
            bad++; $display("FAIL timeout_exit: state=%0d count=%0d ssd=%04h want 0 0 0000", state_code, digit_count, {ssd_3, ssd_2, ssd_1, ssd_0});
        end
        total++;
        if (fail_count !== 2'd1) begin
            bad++; $display("FAIL timeout_fails: got %0d want 1", fail_count);
        end
    endtask

    task automatic test_clear();
        key(4'd9); key(4'd9); key(4'hC);
        total++;
        if (state_code !== 3'd0 || digit_count !== 3'd0 || {ssd_1, ssd_0} !== 8'h0 || fail_count !== 2'd1) begin
            bad++; $display("FAIL clear_entry: state=%0d count=%0d ssd=%02h fails=%0d want 0 0 00 1", state_code, digit_count, {ssd_1, ssd_0}, fail_count);
        end
        key(4'hC); key(4'hA);
        total++;
        if (state_code !== 3'd0 || digit_count !== 3'd0) begin
            bad++; $display("FAIL clear_idle: state=%0d count=%0d want 0 0", state_code, digit_count);
        end
    endtask

    task automatic test_tick_key_collision();
        key(4'd1);
        ticks(ENTRY_TIMEOUT - 1);
        step(1'b1, 4'd2, 1'b1, 1'b0);
        total++;
        if (state_code !== 3'd1 || digit_count !== 3'd2 || {ssd_1, ssd_0} !== 8'h12) begin
            bad++; $display("FAIL collide_key: state=%0d count=%0d ssd=%02h want 1 2 12", state_code, digit_count, {ssd_1, ssd_0});
        end
        ticks(ENTRY_TIMEOUT - 1);
        total++;
        if (state_code !== 3'd1) begin
            bad++; $display("FAIL collide_restart: state=%0d want 1", state_code);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0) begin
            bad++; $display("FAIL collide_timeout: state=%0d want 0", state_code);
        end
    endtask

`ifdef LOCK_LOCKOUT_BACKOFF_EN
    task automatic fail_three();
        for (int a = 0; a < MAX_FAILS; a++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd5);
            idle();
            if (a < MAX_FAILS - 1) ticks(FAIL_TICKS);
        end
    endtask

    task automatic test_backoff();
        step(1'b0, 4'd0, 1'b0, 1'b1);
        password = 16'h1234;
        fail_three();
        ticks(LOCKOUT_TICKS);
        fail_three();
        ticks(2 * LOCKOUT_TICKS - 1);
        total++;
        if (state_code !== 3'd5) begin
            bad++; $display("FAIL backoff_hold: state=%0d want 5", state_code);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0) begin
            bad++; $display("FAIL backoff_exit: state=%0d want 0", state_code);
        end
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        idle();
        ticks(UNLOCK_TICKS);
        fail_three();
        ticks(LOCKOUT_TICKS - 1);
        total++;
        if (state_code !== 3'd5) begin
            bad++; $display("FAIL backoff_reset_hold: state=%0d want 5", state_code);
        end
        ticks(1);
        total++;
        if (state_code !== 3'd0) begin
            bad++; $display("FAIL backoff_reset_exit: state=%0d want 0", state_code);
        end
    endtask
`endif

    task automatic test_random();
        logic       kv, tk, r, dense;
        logic [3:0] kval;
        int         sel, n;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9000; i++) begin
            dense = ((i / 700) % 2) == 0;
            kv    = ($urandom_range(0, dense ? 2 : 299) == 0);
            sel   = $urandom_range(0, 99);
            n     = m_digits.size();
            if (sel < 60 && n < 4) kval = password[15 - 4 * n -: 4];
            else if (sel < 85)     kval = 4'($urandom_range(0, 9));
            else if (sel < 95)     kval = 4'hC;
            else                   kval = 4'($urandom_range(10, 15));
            tk = ($urandom_range(0, 1) == 0);
            r  = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 499) == 0) password = 16'($urandom_range(0, 16'h9999));
            step(kv, kval, tk, r);
            total++;
            if (state_code !== 3'(m_state)) begin
                bad++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", i, state_code, m_state);
            end
            total++;
            if (digit_count !== 3'(m_digits.size()) || {ssd_3, ssd_2, ssd_1, ssd_0} !== exp_digits()) begin
                bad++; $display("FAIL rnd_digits cyc %0d: got %0d/%04h want %0d/%04h", i, digit_count,
                                {ssd_3, ssd_2, ssd_1, ssd_0}, m_digits.size(), exp_digits());
            end
            total++;
            if ({unlocked, fail_flag, lockout} !== {m_state == 3, m_state == 4, m_state == 5} || fail_count !== 2'(m_fails)) begin
                bad++; $display("FAIL rnd_flags cyc %0d: got %03b fails=%0d want state %0d fails=%0d", i,
                                {unlocked, fail_flag, lockout}, fail_count, m_state, m_fails);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_lockout_ignores_keys();
        test_entry_timeout();
        test_clear();
        test_tick_key_collision();
`ifdef LOCK_LOCKOUT_BACKOFF_EN
        test_backoff();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
